// File: rtl/reg_bank_param.sv
// Datapath register bank: NREGS x DATA_W with two registered read ports and write-to-read bypass,
// HI/LO pair, SP/AS stack pointers, ms timer and tick-driven delay countdown.

module reg_bank_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rd_en,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic [NREGS-1:0][DATA_W-1:0]  bank_nxt,
  output logic [DATA_W-1:0]             rd_data
);
  // Reading the post-update image gives the bypass for writes and pointer moves for free.
  always_ff @(posedge clk) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= bank_nxt[rd_addr];
  end
endmodule

module reg_bank_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int SP_IDX   = 31,
  parameter int AS_IDX   = 30,
  parameter int SP_STEP  = 4,
  parameter int TICK_DIV = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr0,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data0,
  output logic [DATA_W-1:0] rd_data1,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              hilo_we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo,
  input  logic              sp_push,
  input  logic              sp_pop,
  input  logic              as_push,
  input  logic              as_pop,
  output logic [DATA_W-1:0] sp_ptr,
  output logic [DATA_W-1:0] as_ptr,
  input  logic              dly_start,
  input  logic [DATA_W-1:0] dly_len,
  output logic              dly_busy,
  output logic [DATA_W-1:0] time_ms
);
  localparam int NREGS = 2**ADDR_W;
  localparam int NRD   = 2;
  localparam int PW    = $clog2(TICK_DIV);
  localparam logic [ADDR_W-1:0] SP_A = ADDR_W'(SP_IDX);
  localparam logic [ADDR_W-1:0] AS_A = ADDR_W'(AS_IDX);

  typedef enum logic {IDLE, RUN} dly_state_t;

  logic [NREGS-1:0][DATA_W-1:0] bank, bank_nxt;
  logic [NRD-1:0][ADDR_W-1:0]   rd_addr;
  logic [NRD-1:0][DATA_W-1:0]   rd_data;

  // Register file next-state: pointer moves first, explicit write overrides them.
  always_comb begin
    bank_nxt = bank;
    if (sp_push && !sp_pop)      bank_nxt[SP_A] = bank[SP_A] + DATA_W'(SP_STEP);
    else if (sp_pop && !sp_push) bank_nxt[SP_A] = bank[SP_A] - DATA_W'(SP_STEP);
    if (as_push && !as_pop)      bank_nxt[AS_A] = bank[AS_A] + DATA_W'(1);
    else if (as_pop && !as_push) bank_nxt[AS_A] = bank[AS_A] - DATA_W'(1);
    if (wr_en) bank_nxt[wr_addr] = wr_data;
    bank_nxt[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) bank <= '0;
    else       bank <= bank_nxt;
  end

  assign sp_ptr = bank[SP_A];
  assign as_ptr = bank[AS_A];

  assign rd_addr[0] = rd_addr0;
  assign rd_addr[1] = rd_addr1;

  generate
    for (genvar p = 0; p < NRD; p++) begin : g_rd
      reg_bank_rdport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) u_rd (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr[p]),
        .bank_nxt (bank_nxt),
        .rd_data  (rd_data[p])
      );
    end
  endgenerate

  assign rd_data0 = rd_data[0];
  assign rd_data1 = rd_data[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (hilo_we) begin
      hi <= hi_in;
      lo <= lo_in;
    end
  end

  // Millisecond timer
  logic [PW-1:0] presc;
  logic          tick;
  assign tick = (presc == PW'(TICK_DIV-1));

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      time_ms <= '0;
    end else if (tick) begin
      presc   <= '0;
      time_ms <= time_ms + DATA_W'(1);
    end else begin
      presc   <= presc + PW'(1);
    end
  end

  // Delay countdown counts ticks only, so it never depends on the time_ms value.
  dly_state_t          state, state_nxt;
  logic [DATA_W-1:0]   cnt, cnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (dly_start) begin
      cnt_nxt   = dly_len;
      state_nxt = (dly_len != '0) ? RUN : IDLE;
    end else if (state == RUN && tick) begin
      cnt_nxt = cnt - DATA_W'(1);
      if (cnt == DATA_W'(1)) state_nxt = IDLE;
    end
  end

  assign dly_busy = (cnt != '0);
endmodule

// File: tb/tb_reg_bank_param.sv
// Self-checking bench for reg_bank_param: vector table, hand corner sequences and randomized
// traffic against an array-based reference model.

module tb_reg_bank_param;
  localparam int DW = 32, AW = 5, TD = 4, NR = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, rd_en, wr_en, hilo_we, sp_push, sp_pop, as_push, as_pop, dly_start;
  logic [AW-1:0] rd_addr0, rd_addr1, wr_addr;
  logic [DW-1:0] wr_data, hi_in, lo_in, dly_len;
  logic [DW-1:0] rd_data0, rd_data1, hi, lo, sp_ptr, as_ptr, time_ms;
  logic          dly_busy;

  reg_bank_param #(.DATA_W(DW), .ADDR_W(AW), .SP_IDX(31), .AS_IDX(30), .SP_STEP(4), .TICK_DIV(TD)) u_dut (
    .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .hilo_we(hilo_we), .hi_in(hi_in), .lo_in(lo_in), .hi(hi), .lo(lo),
    .sp_push(sp_push), .sp_pop(sp_pop), .as_push(as_push), .as_pop(as_pop),
    .sp_ptr(sp_ptr), .as_ptr(as_ptr), .dly_start(dly_start), .dly_len(dly_len),
    .dly_busy(dly_busy), .time_ms(time_ms)
  );

  // Narrow instance used to reach the time_ms and pointer wrap points quickly.
  logic       reset8, sp_pop8;
  logic [7:0] rd0_8, rd1_8, hi8, lo8, sp8, as8, time8;
  logic       busy8;

  reg_bank_param #(.DATA_W(8), .ADDR_W(3), .SP_IDX(7), .AS_IDX(6), .SP_STEP(4), .TICK_DIV(2)) u_w8 (
    .clk(clk), .reset(reset8), .rd_en(1'b0), .rd_addr0(3'd0), .rd_addr1(3'd0),
    .rd_data0(rd0_8), .rd_data1(rd1_8), .wr_en(1'b0), .wr_addr(3'd0), .wr_data(8'd0),
    .hilo_we(1'b0), .hi_in(8'd0), .lo_in(8'd0), .hi(hi8), .lo(lo8),
    .sp_push(1'b0), .sp_pop(sp_pop8), .as_push(1'b0), .as_pop(1'b0),
    .sp_ptr(sp8), .as_ptr(as8), .dly_start(1'b0), .dly_len(8'd0),
    .dly_busy(busy8), .time_ms(time8)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural state only; timer derived from elapsed cycles.
  logic [DW-1:0] m_reg [NR];
  logic [DW-1:0] m_hi, m_lo, m_rd0, m_rd1;
  longint        m_cyc, m_dly;

  task automatic model_step();
    logic [DW-1:0] nr [NR];
    if (reset) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      m_hi = '0; m_lo = '0; m_rd0 = '0; m_rd1 = '0; m_cyc = 0; m_dly = 0;
      return;
    end
    nr = m_reg;
    if (sp_push != sp_pop) nr[31] = sp_push ? m_reg[31] + 32'd4 : m_reg[31] - 32'd4;
    if (as_push != as_pop) nr[30] = as_push ? m_reg[30] + 32'd1 : m_reg[30] - 32'd1;
    if (wr_en && wr_addr != 0) nr[wr_addr] = wr_data;
    if (rd_en) begin
      m_rd0 = nr[rd_addr0];
      m_rd1 = nr[rd_addr1];
    end
    if (hilo_we) begin
      m_hi = hi_in;
      m_lo = lo_in;
    end
    if (dly_start) m_dly = longint'(dly_len);
    else if ((m_cyc % TD) == TD-1 && m_dly > 0) m_dly--;
    m_cyc++;
    m_reg = nr;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("rd_data0", rd_data0, m_rd0);
    chk("rd_data1", rd_data1, m_rd1);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("sp_ptr", sp_ptr, m_reg[31]);
    chk("as_ptr", as_ptr, m_reg[30]);
    chk("time_ms", time_ms, DW'(m_cyc / TD));
    chk("dly_busy", {31'd0, dly_busy}, {31'd0, m_dly != 0});
  endtask

  task automatic idle();
    rd_en = 0; wr_en = 0; hilo_we = 0; sp_push = 0; sp_pop = 0; as_push = 0; as_pop = 0;
    dly_start = 0; rd_addr0 = '0; rd_addr1 = '0; wr_addr = '0; wr_data = '0;
    hi_in = '0; lo_in = '0; dly_len = '0;
  endtask

  function automatic logic [AW-1:0] pick();
    case ($urandom % 5)
      0:       return 5'd0;
      1:       return 5'd5;
      2:       return 5'd30;
      3:       return 5'd31;
      default: return AW'($urandom);
    endcase
  endfunction

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW-1:0] ra0, ra1;
    logic [DW-1:0] e0, e1;
  } vec_t;

  vec_t tbl [6];

  initial begin
    longint t0, t1;
    int k;
    tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF, 32'h0};
    tbl[1] = '{1'b1, 5'd0,  32'h7,        5'd0,  5'd5,  32'h0,        32'hDEADBEEF};
    tbl[2] = '{1'b1, 5'd6,  32'h12345678, 5'd6,  5'd5,  32'h12345678, 32'hDEADBEEF};
    tbl[3] = '{1'b1, 5'd5,  32'h0,        5'd5,  5'd6,  32'h0,        32'h12345678};
    tbl[4] = '{1'b0, 5'd9,  32'hFFFF,     5'd9,  5'd6,  32'h0,        32'h12345678};
    tbl[5] = '{1'b1, 5'd31, 32'h100,      5'd31, 5'd30, 32'h100,      32'h0};

    idle();
    reset8 = 1; sp_pop8 = 0;
    reset = 1; rd_en = 1; rd_addr0 = 5'd31; rd_addr1 = 5'd30;
    cyc(); cyc();
    chk("rst_rd0", rd_data0, 32'h0);
    chk("rst_rd1", rd_data1, 32'h0);
    chk("rst_time", time_ms, 32'h0);
    chk("rst_busy", {31'd0, dly_busy}, 32'h0);

    idle(); reset = 0;
    for (int i = 0; i < 12; i++) cyc();
    chk("time_12cyc", time_ms, 32'd3);

    // Vector table with read-after-write bypass
    for (int i = 0; i < 6; i++) begin
      idle(); rd_en = 1;
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
      rd_addr0 = tbl[i].ra0; rd_addr1 = tbl[i].ra1;
      cyc();
      chk($sformatf("vec%0d_rd0", i), rd_data0, tbl[i].e0);
      chk($sformatf("vec%0d_rd1", i), rd_data1, tbl[i].e1);
    end

    // Stack pointers from reset
    idle(); reset = 1; cyc(); reset = 0;
    sp_pop = 1; rd_en = 1; rd_addr0 = 5'd31; cyc();
    chk("sp_pop0", sp_ptr, 32'hFFFFFFFC);
    chk("sp_pop0_byp", rd_data0, 32'hFFFFFFFC);
    sp_pop = 0; sp_push = 1; cyc(); cyc();
    chk("sp_push2", sp_ptr, 32'h4);
    wr_en = 1; wr_addr = 5'd31; wr_data = 32'h100; cyc();
    chk("sp_wr_wins", sp_ptr, 32'h100);
    chk("sp_wr_byp", rd_data0, 32'h100);
    idle(); as_pop = 1; rd_en = 1; rd_addr1 = 5'd30; cyc();
    chk("as_pop0", as_ptr, 32'hFFFFFFFF);
    chk("as_pop0_byp", rd_data1, 32'hFFFFFFFF);
    as_push = 1; cyc();
    chk("as_pushpop", as_ptr, 32'hFFFFFFFF);

    idle(); hilo_we = 1; hi_in = 32'h1; lo_in = 32'h2; cyc();
    chk("hi_load", hi, 32'h1);
    chk("lo_load", lo, 32'h2);

    // Delay: len 3
    idle(); dly_start = 1; dly_len = 32'd3; cyc(); idle();
    t0 = longint'(time_ms);
    chk("dly3_busy", {31'd0, dly_busy}, 32'h1);
    k = 0;
    while (dly_busy && k < 100) begin cyc(); k++; end
    chk("dly3_ticks", DW'(longint'(time_ms) - t0), 32'd3);

    // Restart after tick 2 with len 5
    dly_start = 1; dly_len = 32'd3; cyc(); idle();
    t0 = longint'(time_ms);
    k = 0;
    while (longint'(time_ms) - t0 < 2 && k < 100) begin cyc(); k++; end
    chk("rst2_busy", {31'd0, dly_busy}, 32'h1);
    dly_start = 1; dly_len = 32'd5; cyc(); idle();
    t1 = longint'(time_ms);
    k = 0;
    while (dly_busy && k < 100) begin cyc(); k++; end
    chk("dly5_ticks", DW'(longint'(time_ms) - t1), 32'd5);

    dly_start = 1; dly_len = 32'd0; cyc(); idle();
    chk("dly0_busy", {31'd0, dly_busy}, 32'h0);

    // Reset mid-countdown
    dly_start = 1; dly_len = 32'd5; cyc(); idle(); cyc(); cyc();
    reset = 1; cyc(); reset = 0;
    chk("rst_run_busy", {31'd0, dly_busy}, 32'h0);
    chk("rst_run_time", time_ms, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom % 100) == 0;
      rd_en     = ($urandom % 4) != 0;
      rd_addr0  = pick(); rd_addr1 = pick();
      wr_en     = $urandom % 2; wr_addr = pick(); wr_data = $urandom;
      hilo_we   = ($urandom % 5) == 0; hi_in = $urandom; lo_in = $urandom;
      sp_push   = ($urandom % 4) == 0; sp_pop = ($urandom % 4) == 0;
      as_push   = ($urandom % 4) == 0; as_pop = ($urandom % 4) == 0;
      dly_start = ($urandom % 20) == 0; dly_len = $urandom % 6;
      cyc();
    end
    idle(); reset = 0;

    // Wrap checks on the 8-bit instance (TICK_DIV=2)
    reset8 = 0; sp_pop8 = 1; cyc(); sp_pop8 = 0;
    chk("w8_sp_pop0", {24'd0, sp8}, 32'hFC);
    for (int i = 1; i < 510; i++) cyc();
    chk("w8_time_max", {24'd0, time8}, 32'hFF);
    cyc(); cyc();
    chk("w8_time_wrap", {24'd0, time8}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
